// File: rtl/seq_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_arith_pkg
//  Purpose  : Opcode encodings and FSM state type for seq_arith_unit.
//  Revision : 1.0
// ============================================================================
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_adder
//  Purpose  : CHUNK-bit ripple-carry adder slice exposing the carry into its
//             top bit so the caller can derive signed overflow.
//  Revision : 1.0
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout  = w_c[CHUNK];
    assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_arith_unit
//  Purpose  : Multi-cycle signed ADD/SUB/NEG/ABS, CHUNK bits per clock through
//             a registered carry, with start/busy/done handshake and overflow.
//  Revision : 1.0
// ============================================================================
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int             N      = WIDTH / CHUNK;
    localparam int             KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic              r_carry;
    logic [KW-1:0]     r_k;

    logic [CHUNK-1:0]  w_a_chk;
    logic [CHUNK-1:0]  w_b_chk;
    logic [CHUNK-1:0]  w_sum;
    logic              w_cout;
    logic              w_c_msb;
    logic [WIDTH-1:0]  w_acc_next;
    logic [WIDTH-1:0]  w_ld_a;
    logic [WIDTH-1:0]  w_ld_b;
    logic              w_ld_cin;

    // Subtraction-style ops become A + ~B + 1 so one adder serves all four.
    always_comb begin
        w_ld_a   = x;
        w_ld_b   = y;
        w_ld_cin = 1'b0;
        case (op)
            OP_ADD: begin
                w_ld_a   = x;
                w_ld_b   = y;
                w_ld_cin = 1'b0;
            end
            OP_SUB: begin
                w_ld_a   = x;
                w_ld_b   = ~y;
                w_ld_cin = 1'b1;
            end
            OP_NEG: begin
                w_ld_a   = '0;
                w_ld_b   = ~x;
                w_ld_cin = 1'b1;
            end
            default: begin
                if (x[WIDTH-1]) begin
                    w_ld_a   = '0;
                    w_ld_b   = ~x;
                    w_ld_cin = 1'b1;
                end else begin
                    w_ld_a   = x;
                    w_ld_b   = '0;
                    w_ld_cin = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        w_a_chk    = '0;
        w_b_chk    = '0;
        w_acc_next = r_acc;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_a_chk                        = r_a[i*CHUNK +: CHUNK];
                w_b_chk                        = r_b[i*CHUNK +: CHUNK];
                w_acc_next[i*CHUNK +: CHUNK]   = w_sum;
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (w_a_chk),
        .b     (w_b_chk),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= w_ld_a;
                        r_b     <= w_ld_b;
                        r_carry <= w_ld_cin;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_k     <= r_k + KW'(1);
                    // Last chunk: its carries are exactly the MSB carry-in/out pair.
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= w_acc_next;
                        ovf     <= w_c_msb ^ w_cout;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_arith_unit
//  Purpose  : Scoreboard bench: directed vectors on an 8/2 instance plus a
//             random sweep on 16/4 and 8/8 instances against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_seq_arith_unit;

    localparam int N0 = 4;
    localparam int N1 = 4;
    localparam int N2 = 1;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        m_start = 1'b0;
    logic [1:0]  m_op    = 2'b00;
    logic [7:0]  m_x     = '0;
    logic [7:0]  m_y     = '0;
    logic        busy0, done0, ovf0;
    logic [7:0]  result0;

    logic        s_start = 1'b0;
    logic [1:0]  s_op    = 2'b00;
    logic [15:0] s_x     = '0;
    logic [15:0] s_y     = '0;
    logic        busy1, done1, ovf1;
    logic [15:0] result1;
    logic        busy2, done2, ovf2;
    logic [7:0]  result2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic pdone0 = 1'b0, pdone1 = 1'b0, pdone2 = 1'b0;
    int   run0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_arith_unit #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst(rst), .start(m_start), .op(m_op), .x(m_x), .y(m_y),
        .busy(busy0), .done(done0), .result(result0), .ovf(ovf0)
    );

    seq_arith_unit #(.WIDTH(16), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .x(s_x), .y(s_y),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1)
    );

    seq_arith_unit #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .x(s_x[7:0]), .y(s_y[7:0]),
        .busy(busy2), .done(done2), .result(result2), .ovf(ovf2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: exact signed value, then wrap and range-test.
    function automatic void ref_model(input int w, input logic [1:0] op,
                                      input logic [15:0] x, input logic [15:0] y,
                                      output logic [15:0] r, output logic o);
        longint mask, sx, sy, t, lo, hi;
        mask = (64'sd1 <<< w) - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (sx >= (64'sd1 <<< (w - 1))) sx = sx - (64'sd1 <<< w);
        if (sy >= (64'sd1 <<< (w - 1))) sy = sy - (64'sd1 <<< w);
        case (op)
            2'b00:   t = sx + sy;
            2'b01:   t = sx - sy;
            2'b10:   t = -sx;
            default: t = (sx < 0) ? -sx : sx;
        endcase
        lo = -(64'sd1 <<< (w - 1));
        hi = (64'sd1 <<< (w - 1)) - 1;
        o  = (t < lo) || (t > hi);
        t  = t & mask;
        r  = t[15:0];
    endfunction

    // Monitors: pop expected entry whenever the DUT presents done.
    always @(negedge clk) begin
        chk("busy_done_overlap0", 32'(busy0 & done0), 32'd0);
        chk("done_twice0", 32'(done0 & pdone0), 32'd0);
        pdone0 <= done0;
        if (busy0) begin
            run0 <= run0 + 1;
        end else begin
            if (done0) chk("busy_cycles0", run0, N0);
            run0 <= 0;
        end
        if (done0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 32'd1, 32'd0);
            end else begin
                chk("result0", 32'(result0), 32'(q0[0].res));
                chk("ovf0", 32'(ovf0), 32'(q0[0].ovf));
                chk("latency0", cyc, q0[0].cyc);
                void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_done_overlap1", 32'(busy1 & done1), 32'd0);
        chk("done_twice1", 32'(done1 & pdone1), 32'd0);
        pdone1 <= done1;
        if (done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 32'd1, 32'd0);
            end else begin
                chk("result1", 32'(result1), 32'(q1[0].res));
                chk("ovf1", 32'(ovf1), 32'(q1[0].ovf));
                chk("latency1", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_done_overlap2", 32'(busy2 & done2), 32'd0);
        chk("done_twice2", 32'(done2 & pdone2), 32'd0);
        pdone2 <= done2;
        if (done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 32'd1, 32'd0);
            end else begin
                chk("result2", 32'(result2), 32'(q2[0].res));
                chk("ovf2", 32'(ovf2), 32'(q2[0].ovf));
                chk("latency2", cyc, q2[0].cyc);
                void'(q2.pop_front());
            end
        end
    end

    task automatic run0_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic eo);
        @(negedge clk);
        m_start = 1'b1; m_op = op; m_x = x; m_y = y;
        q0.push_back('{res: 16'(er), ovf: eo, cyc: cyc + 1 + N0});
        @(negedge clk);
        m_start = 1'b0;
        repeat (N0) @(negedge clk);
    endtask

    task automatic run_sweep(input int iters);
        logic [15:0] r;
        logic        o;
        logic [15:0] corners [6];
        corners = '{16'h8000, 16'h7FFF, 16'h0080, 16'hFF80, 16'h0000, 16'hFFFF};
        for (int i = 0; i < iters; i++) begin
            @(negedge clk);
            s_start = 1'b1;
            s_op    = 2'($urandom_range(0, 3));
            s_x     = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            s_y     = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            ref_model(16, s_op, s_x, s_y, r, o);
            q1.push_back('{res: r, ovf: o, cyc: cyc + 1 + N1});
            ref_model(8, s_op, s_x, s_y, r, o);
            q2.push_back('{res: r, ovf: o, cyc: cyc + 1 + N2});
            @(negedge clk);
            s_start = 1'b0;
            repeat (N1) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_result0", 32'(result0), 32'd0);
        chk("reset_ovf0", 32'(ovf0), 32'd0);
        chk("reset_result1", 32'(result1), 32'd0);
        chk("reset_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Directed vectors, hand-computed results.
        run0_op(2'b00, 8'h05, 8'h03, 8'h08, 1'b0);
        run0_op(2'b00, 8'h7F, 8'h01, 8'h80, 1'b1);
        run0_op(2'b01, 8'h80, 8'h01, 8'h7F, 1'b1);
        run0_op(2'b01, 8'h03, 8'h05, 8'hFE, 1'b0);
        run0_op(2'b10, 8'h80, 8'h00, 8'h80, 1'b1);
        run0_op(2'b10, 8'h00, 8'h5A, 8'h00, 1'b0);
        run0_op(2'b11, 8'hFB, 8'h00, 8'h05, 1'b0);
        run0_op(2'b11, 8'h05, 8'h00, 8'h05, 1'b0);
        run0_op(2'b11, 8'h80, 8'h33, 8'h80, 1'b1);

        // start held through CALC with changing inputs, then accepted in DONE.
        @(negedge clk);
        m_start = 1'b1; m_op = 2'b00; m_x = 8'h01; m_y = 8'h02;
        q0.push_back('{res: 16'h0003, ovf: 1'b0, cyc: cyc + 1 + N0});
        for (int i = 0; i < N0; i++) begin
            @(negedge clk);
            m_op = 2'(i); m_x = 8'($urandom); m_y = 8'($urandom);
        end
        @(negedge clk);
        chk("held_start_in_done", 32'(done0), 32'd1);
        m_op = 2'b01; m_x = 8'h09; m_y = 8'h04;
        q0.push_back('{res: 16'h0005, ovf: 1'b0, cyc: cyc + 1 + N0});
        @(negedge clk);
        m_start = 1'b0;
        repeat (N0) @(negedge clk);

        // Reset in the second CALC cycle aborts the operation.
        @(negedge clk);
        m_start = 1'b1; m_op = 2'b00; m_x = 8'h11; m_y = 8'h22;
        @(negedge clk);
        m_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_result", 32'(result0), 32'd0);
        chk("abort_ovf", 32'(ovf0), 32'd0);
        repeat (6) @(negedge clk);
        run0_op(2'b00, 8'h10, 8'h20, 8'h30, 1'b0);

        run_sweep(1000);

        repeat (8) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
